// File: rtl/mux_frame_pkg.sv
// Shared types and constants for the 4-lane frame demultiplexer.
package mux_frame_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] LANE_A = 2'b00;
    localparam logic [1:0] LANE_B = 2'b01;
    localparam logic [1:0] LANE_C = 2'b10;
    localparam logic [1:0] LANE_D = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    // One-hot lane decode, bit0 = lane A.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/mux_frame_lane_ptr.sv
// 2-bit round-robin lane pointer. Held at lane A while hold_zero is high so
// every entry into auto mode starts a fresh rotation at A.
module mux_frame_lane_ptr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic       hold_zero,
    output logic [1:0] ptr
);

    logic [1:0] ptr_q, ptr_d;

    // Next pointer: hold_zero dominates, otherwise wrap-increment on advance.
    always_comb begin
        ptr_d = ptr_q;
        if (hold_zero)
            ptr_d = 2'd0;
        else if (advance)
            ptr_d = ptr_q + 2'd1;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr_q <= 2'd0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/mux_frame_demux.sv
// Receive-side 1:4 frame demultiplexer. Beats fill a shadow register set;
// once all four lanes have been written the frame is published atomically
// on A-D with a one-cycle frame_valid strobe.
// Optional: define MUX_FRAME_DEMUX_OVERRUN_EN to build sticky rewrite
// detection on 'overrun'; otherwise 'overrun' is tied low.
import mux_frame_pkg::*;

module mux_frame_demux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             enable,
    input  logic             auto_mode,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic             frame_valid,
    output logic [3:0]       lane_mask,
    output logic             overrun
);

    logic                             acc;
    logic [1:0]                       ptr;
    logic [1:0]                       lane;
    logic [NUM_LANES-1:0]             hit;
    logic [NUM_LANES-1:0]             mask_set;
    logic [NUM_LANES-1:0]             mask_q, mask_d;
    state_e                           state_q, state_d;
    logic [NUM_LANES-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [NUM_LANES-1:0][WIDTH-1:0]  pub_q, pub_d;
    logic                             fv_q, fv_d;

    assign acc  = enable & din_valid;
    assign lane = auto_mode ? ptr : sel;
    assign hit  = lane_onehot(lane);

    mux_frame_lane_ptr u_ptr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (acc & auto_mode),
        .hold_zero (~auto_mode),
        .ptr       (ptr)
    );

    // Shadow write, mask accumulation and frame completion. The completing
    // beat is merged into the published frame through shadow_d.
    always_comb begin
        shadow_d = shadow_q;
        mask_d   = mask_q;
        state_d  = state_q;
        pub_d    = pub_q;
        fv_d     = 1'b0;
        mask_set = mask_q | hit;
        if (acc) begin
            shadow_d[lane] = din;
            case (state_q)
                IDLE: begin
                    mask_d  = hit;
                    state_d = FILL;
                end
                FILL: begin
                    if (mask_set == 4'b1111) begin
                        pub_d   = shadow_d;
                        mask_d  = '0;
                        fv_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        mask_d  = mask_set;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, shadow and publish registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            shadow_q <= '0;
            pub_q    <= '0;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            shadow_q <= shadow_d;
            pub_q    <= pub_d;
            fv_q     <= fv_d;
        end
    end

`ifdef MUX_FRAME_DEMUX_OVERRUN_EN
    logic ovr_q, ovr_d;

    // Sticky: any accepted beat landing on a lane already filled this frame.
    always_comb begin
        ovr_d = ovr_q | (acc & (|(mask_q & hit)));
    end

    // Overrun register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_q <= 1'b0;
        else
            ovr_q <= ovr_d;
    end

    assign overrun = ovr_q;
`else
    assign overrun = 1'b0;
`endif

    assign A           = pub_q[LANE_A];
    assign B           = pub_q[LANE_B];
    assign C           = pub_q[LANE_C];
    assign D           = pub_q[LANE_D];
    assign frame_valid = fv_q;
    assign lane_mask   = mask_q;

endmodule

// File: tb/tb_mux_frame_demux.sv
// Self-checking bench for mux_frame_demux: directed scenarios plus random
// traffic against a lane-set reference model.
module tb_mux_frame_demux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         enable = 1'b0;
    logic         auto_mode = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [W-1:0] A, B, C, D;
    logic         frame_valid;
    logic [3:0]   lane_mask;
    logic         overrun;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [W-1:0] m_sh  [4];
    logic [W-1:0] m_out [4];
    bit           m_wr  [4];
    int           m_ptr;
    bit           m_fv;
    bit           m_ovr;

    mux_frame_demux #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .enable      (enable),
        .auto_mode   (auto_mode),
        .sel         (sel),
        .A           (A),
        .B           (B),
        .C           (C),
        .D           (D),
        .frame_valid (frame_valid),
        .lane_mask   (lane_mask),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = '0;
            m_out[i] = '0;
            m_wr[i]  = 1'b0;
        end
        m_ptr = 0;
        m_fv  = 1'b0;
        m_ovr = 1'b0;
    endtask

    // A frame is the set of lanes written since the last publish; it is
    // published when that set covers all four lanes.
    task automatic model_step(input bit en, input bit dv, input bit au,
                              input int s, input logic [W-1:0] d);
        int lane;
        int cnt;
        m_fv = 1'b0;
        if (en && dv) begin
            lane = au ? m_ptr : s;
`ifdef MUX_FRAME_DEMUX_OVERRUN_EN
            if (m_wr[lane]) m_ovr = 1'b1;
`endif
            m_sh[lane] = d;
            m_wr[lane] = 1'b1;
            cnt = 0;
            for (int i = 0; i < 4; i++) if (m_wr[i]) cnt++;
            if (cnt == 4) begin
                for (int i = 0; i < 4; i++) begin
                    m_out[i] = m_sh[i];
                    m_wr[i]  = 1'b0;
                end
                m_fv = 1'b1;
            end
            if (au) m_ptr = (m_ptr + 1) % 4;
        end
        if (!au) m_ptr = 0;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] em;
        em = {m_wr[3], m_wr[2], m_wr[1], m_wr[0]};
        chk({tag, ".A"}, 32'(A), 32'(m_out[0]));
        chk({tag, ".B"}, 32'(B), 32'(m_out[1]));
        chk({tag, ".C"}, 32'(C), 32'(m_out[2]));
        chk({tag, ".D"}, 32'(D), 32'(m_out[3]));
        chk({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
        chk({tag, ".mask"}, 32'(lane_mask), 32'(em));
        chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    // Drive one cycle's inputs, advance the model, check 1 time unit after the edge.
    task automatic cyc(input string tag, input bit en, input bit dv, input bit au,
                       input int s, input logic [W-1:0] d);
        enable    = en;
        din_valid = dv;
        auto_mode = au;
        sel       = 2'(s);
        din       = d;
        model_step(en, dv, au, s, d);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    int nframes;

    initial begin
        model_reset();

        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            enable    = 1'($urandom);
            din_valid = 1'($urandom);
            auto_mode = 1'($urandom);
            sel       = 2'($urandom);
            din       = 8'($urandom);
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("idle", 1'b1, 1'b0, 1'b0, 0, 8'h00);

        // Auto mode rotation
        cyc("auto0", 1'b1, 1'b1, 1'b1, 0, 8'h11);
        cyc("auto1", 1'b1, 1'b1, 1'b1, 0, 8'h22);
        cyc("auto2", 1'b1, 1'b1, 1'b1, 0, 8'h33);
        cyc("auto3", 1'b1, 1'b1, 1'b1, 0, 8'h44);
        chk("auto.A_const", 32'(A), 32'h11);
        chk("auto.D_const", 32'(D), 32'h44);
        cyc("auto_after", 1'b1, 1'b0, 1'b0, 0, 8'h00);

        // Explicit out-of-order
        cyc("ooo0", 1'b1, 1'b1, 1'b0, 3, 8'hD0);
        chk("ooo.mask1", 32'(lane_mask), 32'b1000);
        cyc("ooo1", 1'b1, 1'b1, 1'b0, 1, 8'hB0);
        cyc("ooo2", 1'b1, 1'b1, 1'b0, 0, 8'hA0);
        chk("ooo.mask3", 32'(lane_mask), 32'b1011);
        cyc("ooo3", 1'b1, 1'b1, 1'b0, 2, 8'hC0);
        chk("ooo.C_const", 32'(C), 32'hC0);

        // Rewrite / overrun
        cyc("rw0", 1'b1, 1'b1, 1'b0, 0, 8'h01);
        cyc("rw1", 1'b1, 1'b1, 1'b0, 0, 8'h02);
        cyc("rw2", 1'b1, 1'b1, 1'b0, 1, 8'h03);
        cyc("rw3", 1'b1, 1'b1, 1'b0, 2, 8'h04);
        cyc("rw4", 1'b1, 1'b1, 1'b0, 3, 8'h05);
        chk("rw.A_const", 32'(A), 32'h02);

        // Enable gating
        for (int i = 0; i < 4; i++) cyc("gate_off", 1'b0, 1'b1, 1'b1, i, 8'($urandom));
        for (int i = 0; i < 4; i++) cyc("gate_on", 1'b1, 1'b1, 1'b1, 0, 8'(8'h60 + i));

        // Mid-frame asynchronous reset
        cyc("mid0", 1'b1, 1'b1, 1'b0, 2, 8'hE1);
        cyc("mid1", 1'b1, 1'b1, 1'b0, 1, 8'hE2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc("post_rst", 1'b1, 1'b1, 1'b1, 0, 8'(8'h70 + i));

        // Random traffic
        nframes = 0;
        for (int i = 0; i < 400; i++) begin
            bit au;
            au = ((i / 23) % 2) == 1 ? 1'b1 : ($urandom_range(0, 9) == 0);
            cyc("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, au,
                int'($urandom_range(0, 3)), 8'($urandom));
            if (m_fv) nframes++;
        end
        if (nframes == 0) chk("rand.frames_seen", 32'(nframes), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
